cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus between the execution units that produce tagged results (ALU, Load unit, and one spare port reserved for a future multiply/divide unit). Each cycle it selects at most one pending result, acknowledges that requester, and drives a registered broadcast of the tag and value to the ROB, the reservation stations and the PC. It also discards results on a ROB misprediction flush.

## Interface
- TAG_W, default 5: result tag width; equals the ROB entry / register-lock width.
- DATA_W, default 32: result value width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  ROB misprediction redirect (ROB `pc_modify`); discards in-flight results.
- req_valid  in  3  per-requester result pending; bit 0 ALU, bit 1 Load, bit 2 spare.
- req_index  in  3*TAG_W  per-requester tag; requester k occupies bits [k*TAG_W +: TAG_W].
- req_result  in  3*DATA_W  per-requester value, packed as for req_index.
- req_ready  out  3  one-hot or zero grant; the requester's transfer completes in a cycle where valid and ready are both high.
- cdb_valid  out  1  broadcast valid.
- cdb_index  out  TAG_W  broadcast tag.
- cdb_result  out  DATA_W  broadcast value.
- busy_cycles  out  16  saturating count of cycles in which cdb_valid was high (performance counter).

## Operation
- State: 2-bit round-robin pointer `prio` (values 0..2), output register {cdb_valid, cdb_index, cdb_result}, busy_cycles counter.
- Grant (combinational): scan requesters starting at `prio`, wrapping 2→0; the first with req_valid high gets req_ready high. At most one ready bit is high. With no valid requester, req_ready = 0.
- Flush: while flush is high, req_ready = 0 regardless of req_valid (requesters must drop stale results themselves).
- On the rising edge, if a grant occurred (and no flush or rst): cdb_valid ← 1, cdb_index/cdb_result ← the granted requester's fields, and `prio` ← granted index + 1 (mod 3).
- If no grant: cdb_valid ← 0, and cdb_index and cdb_result hold their previous values. `prio` is unchanged.
- Flush: cdb_valid ← 0 on the next edge, and `prio` is unchanged.
- Requester rule: once req_valid is raised, req_index and req_result stay stable until the cycle in which ready is seen. The arbiter never grants a requester whose valid is low.
- busy_cycles increments on every edge at which cdb_valid is 1, saturates at 16'hFFFF, and is cleared only by rst.
- Tag value 0 is a legal tag. Consumers qualify the broadcast with cdb_valid, never with tag ≠ 0.

## Timing
- Reset values: cdb_valid 0, cdb_index 0, cdb_result 0, busy_cycles 0, `prio` 0. During rst, req_ready = 0.
- Latency: a request granted in cycle t appears on the CDB in cycle t+1 for exactly one cycle.
- Throughput: one result per cycle. Back-to-back grants to different or identical requesters are allowed.
- Fairness: any continuously valid requester is granted within 3 cycles.
- Simultaneous flush and request: no grant, and no broadcast in the next cycle.
- Flush in cycle t also clears a broadcast that would have started in t+1. A broadcast already visible in cycle t remains valid for that cycle.
- Reset mid-transfer: the result captured in the edge asserting rst is dropped, and cdb_valid is 0 in the following cycle.

## Test plan
- Reset, then idle: hold rst 1 for 2 cycles with all req_valid = 1. Required: req_ready = 0 and cdb_valid = 0 throughout. After release, the first grant goes to ALU (prio 0).
- Single request: ALU valid with tag 3, value 0x0000_00AA in cycle t. Required: req_ready = 3'b001 in t; cdb_valid = 1, index 3, value 0xAA in t+1; cdb_valid = 0 in t+2.
- Contention rotation: all three valid continuously with tags 1, 2, 3. Required: grants in the order 001, 010, 100, 001 …; CDB tags in the order 1, 2, 3, 1; no idle cycles.
- Skip and wrap: prio = 2, only ALU and Load valid. Required: ALU is granted first (wrap), then Load.
- Flush: Load valid with tag 7 and flush = 1 in cycle t. Required: req_ready = 0 in t and cdb_valid = 0 in t+1. With flush = 0 in t+1, Load (still valid) is granted in t+1 and broadcasts in t+2.
- Counter: 10 consecutive grants. Required: busy_cycles = 10. Forcing 70000 busy cycles yields busy_cycles = 16'hFFFF.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin Common Data Bus arbiter with registered broadcast
//
// Shares one result bus between three tagged-result producers
// (bit 0 ALU, bit 1 Load, bit 2 spare for a future mul/div unit).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           ROB misprediction redirect; suppresses grants and broadcast
//   req_valid[3]    per-requester result pending
//   req_index       packed per-requester tags, requester k at [k*TAG_W +: TAG_W]
//   req_result      packed per-requester values, same packing
//   req_ready[3]    one-hot (or zero) grant; transfer on valid & ready
//   cdb_valid       registered broadcast valid
//   cdb_index       registered broadcast tag (holds when idle)
//   cdb_result      registered broadcast value (holds when idle)
//   busy_cycles     saturating count of cycles with cdb_valid high

module cdb_arbiter #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [2:0]          req_valid,
  input  logic [3*TAG_W-1:0]  req_index,
  input  logic [3*DATA_W-1:0] req_result,
  output logic [2:0]          req_ready,
  output logic                cdb_valid,
  output logic [TAG_W-1:0]    cdb_index,
  output logic [DATA_W-1:0]   cdb_result,
  output logic [15:0]         busy_cycles
);

  logic [1:0] prio;
  logic       grant_any;
  logic [1:0] grant_idx;

  // Returns {found, index} for the first valid requester in the order a, b, c.
  function automatic logic [2:0] first_of(input logic [2:0] v,
                                          input logic [1:0] a,
                                          input logic [1:0] b,
                                          input logic [1:0] c);
    if (v[a])      return {1'b1, a};
    else if (v[b]) return {1'b1, b};
    else if (v[c]) return {1'b1, c};
    else           return 3'b000;
  endfunction

  always_comb begin
    logic [2:0] pick;
    pick      = 3'b000;
    grant_any = 1'b0;
    grant_idx = 2'd0;
    req_ready = 3'b000;
    if (!rst && !flush) begin
      case (prio)
        2'd1:    pick = first_of(req_valid, 2'd1, 2'd2, 2'd0);
        2'd2:    pick = first_of(req_valid, 2'd2, 2'd0, 2'd1);
        default: pick = first_of(req_valid, 2'd0, 2'd1, 2'd2);
      endcase
      grant_any = pick[2];
      grant_idx = pick[1:0];
      if (grant_any) req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio        <= 2'd0;
      cdb_valid   <= 1'b0;
      cdb_index   <= '0;
      cdb_result  <= '0;
      busy_cycles <= 16'd0;
    end else begin
      // Counts the broadcast currently on the bus, not the one being captured.
      if (cdb_valid && busy_cycles != 16'hFFFF)
        busy_cycles <= busy_cycles + 16'd1;
      // grant_any is already forced low during flush, so flush needs no term here.
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_index  <= req_index[grant_idx*TAG_W +: TAG_W];
        cdb_result <= req_result[grant_idx*DATA_W +: DATA_W];
        prio       <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector testbench for cdb_arbiter

module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  req_valid;
  logic [14:0] req_index;
  logic [95:0] req_result;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [4:0]  cdb_index;
  logic [31:0] cdb_result;
  logic [15:0] busy_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_index(req_index), .req_result(req_result),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_index(cdb_index),
    .cdb_result(cdb_result), .busy_cycles(busy_cycles)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic [2:0]  v;
    logic [4:0]  t0, t1, t2;
    logic [2:0]  rdy;
    logic        cv;
    logic [4:0]  ci;
    logic [31:0] cr;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Requester k's value is (k+1)<<28 | tag, so the table can name expected values.
  task automatic drive(input logic r, input logic f, input logic [2:0] v,
                       input logic [4:0] t0, input logic [4:0] t1, input logic [4:0] t2);
    rst        = r;
    flush      = f;
    req_valid  = v;
    req_index  = {t2, t1, t0};
    req_result = {32'h3000_0000 | {27'd0, t2}, 32'h2000_0000 | {27'd0, t1},
                  32'h1000_0000 | {27'd0, t0}};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Row: rst flush valid t0 t1 t2 | ready cdb_valid cdb_index cdb_result (as seen this cycle)
    tbl[0]  = '{1'b1, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b0, 5'd0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd1, 32'h1000_0001};
    tbl[4]  = '{1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd2, 32'h2000_0002};
    tbl[5]  = '{1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd3, 32'h3000_0003};
    tbl[6]  = '{1'b0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 5'd1, 32'h1000_0001};
    tbl[7]  = '{1'b0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd1, 32'h1000_0001};
    tbl[8]  = '{1'b0, 1'b0, 3'b010, 5'd1, 5'd2, 5'd3, 3'b010, 1'b0, 5'd1, 32'h1000_0001};
    tbl[9]  = '{1'b0, 1'b0, 3'b011, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd2, 32'h2000_0002};
    tbl[10] = '{1'b0, 1'b0, 3'b011, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd1, 32'h1000_0001};
    tbl[11] = '{1'b0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 5'd2, 32'h2000_0002};
    tbl[12] = '{1'b0, 1'b1, 3'b010, 5'd1, 5'd7, 5'd3, 3'b000, 1'b0, 5'd2, 32'h2000_0002};
    tbl[13] = '{1'b0, 1'b0, 3'b010, 5'd1, 5'd7, 5'd3, 3'b010, 1'b0, 5'd2, 32'h2000_0002};
    tbl[14] = '{1'b0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 5'd7, 32'h2000_0007};
    tbl[15] = '{1'b0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd7, 32'h2000_0007};
    tbl[16] = '{1'b0, 1'b0, 3'b100, 5'd1, 5'd2, 5'd3, 3'b100, 1'b0, 5'd7, 32'h2000_0007};
    tbl[17] = '{1'b0, 1'b1, 3'b001, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 5'd3, 32'h3000_0003};
    tbl[18] = '{1'b0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd3, 32'h3000_0003};
    tbl[19] = '{1'b0, 1'b0, 3'b001, 5'd1, 5'd2, 5'd3, 3'b001, 1'b0, 5'd3, 32'h3000_0003};
    tbl[20] = '{1'b1, 1'b0, 3'b001, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 5'd1, 32'h1000_0001};
    tbl[21] = '{1'b0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 32'h0};

    drive(1'b1, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3);
    tick();
    chk("reset_busy", {16'd0, busy_cycles}, 32'd0);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].v, tbl[i].t0, tbl[i].t1, tbl[i].t2);
      #4;
      chk($sformatf("row%0d_ready", i), {29'd0, req_ready}, {29'd0, tbl[i].rdy});
      chk($sformatf("row%0d_cdb_valid", i), {31'd0, cdb_valid}, {31'd0, tbl[i].cv});
      chk($sformatf("row%0d_cdb_index", i), {27'd0, cdb_index}, {27'd0, tbl[i].ci});
      chk($sformatf("row%0d_cdb_result", i), cdb_result, tbl[i].cr);
      tick();
    end

    // Single ALU request, tag 3 value 0xAA (prio is 0 after the reset in row 20).
    rst = 1'b0; flush = 1'b0;
    req_valid = 3'b001; req_index = {5'd0, 5'd0, 5'd3}; req_result = {64'd0, 32'h0000_00AA};
    #4 chk("single_ready", {29'd0, req_ready}, 32'd1);
    tick();
    req_valid = 3'b000;
    #4;
    chk("single_cdb_valid", {31'd0, cdb_valid}, 32'd1);
    chk("single_cdb_index", {27'd0, cdb_index}, 32'd3);
    chk("single_cdb_result", cdb_result, 32'h0000_00AA);
    tick();
    chk("single_cdb_idle", {31'd0, cdb_valid}, 32'd0);
    chk("single_busy", {16'd0, busy_cycles}, 32'd1);

    // Ten consecutive grants from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 3'b001; req_index = {5'd0, 5'd0, 5'd0}; req_result = 96'd0;
    repeat (10) tick();
    req_valid = 3'b000;
    tick();
    chk("count10_busy", {16'd0, busy_cycles}, 32'd10);
    chk("count10_idle", {31'd0, cdb_valid}, 32'd0);

    // Saturation: well over 65535 busy cycles.
    req_valid = 3'b001;
    repeat (70000) tick();
    chk("sat_busy", {16'd0, busy_cycles}, 32'h0000_FFFF);
    req_valid = 3'b000;
    repeat (3) tick();
    chk("sat_hold", {16'd0, busy_cycles}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
